// File: rtl/obj_scan_sched.sv
// Per-scanline object scheduler: scans one object-RAM bank for sprites that hit the next
// line and queues draw descriptors, while sharing the RAM port with the Z80 (Z80 first).
module obj_scan_sched #(
    parameter int NUM_OBJ      = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_PER_LINE = 16
) (
    input  logic       clkm_48MHZ,
    input  logic       reset,
    input  logic       line_start,
    input  logic [7:0] vpos,
    input  logic       objex,
    input  logic       obj_enable,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    output logic       cpu_ack,
    output logic [7:0] ram_addr,
    output logic       ram_we,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic       desc_valid,
    input  logic       desc_ready,
    output logic [7:0] desc_code,
    output logic [7:0] desc_x,
    output logic [3:0] desc_row,
    output logic [7:0] desc_attr,
    output logic       sel_buf,
    output logic       clr_req,
    output logic       busy,
    output logic       ovf
);
    localparam int IDX_W = $clog2(NUM_OBJ);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int HIT_W = $clog2(MAX_PER_LINE + 1);

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] x;
        logic [3:0] row;
        logic [7:0] attr;
    } desc_t;

    typedef enum logic [2:0] {IDLE, S_Y, S_CHK, S_X, S_C, S_A, S_W, S_PUSH} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [HIT_W-1:0] hit_cnt;
    logic [7:0]       vpos_l;
    logic             bank_l;
    logic [3:0]       row;
    logic [7:0]       cur_x, cur_code, cur_attr;

    logic             grant, grant_q, ack_rd_q;
    logic [1:0]       scan_off;
    logic             scan_drv;
    logic [7:0]       d;
    logic             adv_last;

    desc_t            fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic             full, empty, push, pop;
    desc_t            head;

    // The Z80 wins any cycle unless it was granted the cycle before; reset drops the grant.
    assign grant = cpu_req && !grant_q && !reset;

    always_ff @(posedge clkm_48MHZ) begin
        if (reset) begin
            grant_q  <= 1'b0;
            ack_rd_q <= 1'b0;
        end else begin
            grant_q  <= grant;
            ack_rd_q <= grant && !cpu_we;
        end
    end

    assign cpu_ack  = grant_q;
    assign cpu_dout = (grant_q && ack_rd_q) ? ram_rdata : 8'h00;

    always_comb begin
        scan_off  = 2'd0;
        scan_drv  = 1'b0;
        case (state)
            S_Y:     begin scan_drv = 1'b1; scan_off = 2'd0; end
            S_X:     begin scan_drv = 1'b1; scan_off = 2'd1; end
            S_C:     begin scan_drv = 1'b1; scan_off = 2'd2; end
            S_A:     begin scan_drv = 1'b1; scan_off = 2'd3; end
            default: ;
        endcase
        ram_addr  = 8'h00;
        ram_we    = 1'b0;
        ram_wdata = 8'h00;
        if (grant) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_din;
        end else if (scan_drv) begin
            ram_addr  = 8'({bank_l, idx, scan_off});
        end
    end

    // Sprite is on line vpos+1 when Y + vpos + 1 lands in 0xF0..0xFF.
    assign d        = ram_rdata + vpos_l + 8'd1;
    assign adv_last = (idx == IDX_W'(NUM_OBJ - 1)) || !obj_enable;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push  = (state == S_PUSH) && !full && !line_start;
    assign pop   = !empty && desc_ready && !line_start;
    assign head  = fifo_mem[rd_ptr[PTR_W-1:0]];

    assign desc_valid = !empty;
    assign desc_code  = empty ? 8'h00 : head.code;
    assign desc_x     = empty ? 8'h00 : head.x;
    assign desc_row   = empty ? 4'h0  : head.row;
    assign desc_attr  = empty ? 8'h00 : head.attr;
    assign busy       = (state != IDLE);

    always_ff @(posedge clkm_48MHZ) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= '{code: cur_code, x: cur_x, row: row, attr: cur_attr};
    end

    always_ff @(posedge clkm_48MHZ) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            hit_cnt  <= '0;
            vpos_l   <= 8'h00;
            bank_l   <= 1'b0;
            row      <= 4'h0;
            cur_x    <= 8'h00;
            cur_code <= 8'h00;
            cur_attr <= 8'h00;
            sel_buf  <= 1'b0;
            clr_req  <= 1'b0;
            ovf      <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            clr_req <= 1'b0;
            if (line_start) begin
                sel_buf <= ~sel_buf;
                clr_req <= 1'b1;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                ovf     <= 1'b0;
                hit_cnt <= '0;
                vpos_l  <= vpos;
                bank_l  <= objex;
                idx     <= '0;
                state   <= obj_enable ? S_Y : IDLE;
            end else begin
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                // Data-capture states skip the capture when the previous cycle was a Z80
                // grant: the RAM data then belongs to the Z80, and the address is re-issued.
                case (state)
                    S_Y: if (!grant) state <= S_CHK;
                    S_CHK: begin
                        if (d[7:4] == 4'hF) begin
                            row   <= d[3:0];
                            state <= S_X;
                        end else if (adv_last) begin
                            state <= IDLE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= S_Y;
                        end
                    end
                    S_X: if (!grant) state <= S_C;
                    S_C: begin
                        if (!grant_q) cur_x <= ram_rdata;
                        if (!grant) state <= S_A;
                    end
                    S_A: begin
                        if (!grant_q) cur_code <= ram_rdata;
                        if (!grant) state <= S_W;
                    end
                    S_W: begin
                        cur_attr <= ram_rdata;
                        if (ram_rdata[1]) row <= ~row;
                        state <= S_PUSH;
                    end
                    S_PUSH: begin
                        if (!full) begin
                            hit_cnt <= hit_cnt + HIT_W'(1);
                            if (hit_cnt == HIT_W'(MAX_PER_LINE - 1)) begin
                                ovf   <= 1'b1;
                                state <= IDLE;
                            end else if (adv_last) begin
                                state <= IDLE;
                            end else begin
                                idx   <= idx + IDX_W'(1);
                                state <= S_Y;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_obj_scan_sched.sv
// Directed bench for obj_scan_sched with a behavioural object RAM (1-cycle read latency).
module tb_obj_scan_sched;
    logic       clkm_48MHZ = 1'b0;
    logic       reset = 1'b1, line_start = 1'b0, objex = 1'b0, obj_enable = 1'b0;
    logic [7:0] vpos = 8'h00;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_addr = 8'h00, cpu_din = 8'h00, cpu_dout;
    logic       cpu_ack;
    logic [7:0] ram_addr, ram_wdata;
    logic [7:0] ram_rdata = 8'h00;
    logic       ram_we;
    logic       desc_valid, desc_ready = 1'b0;
    logic [7:0] desc_code, desc_x, desc_attr;
    logic [3:0] desc_row;
    logic       sel_buf, clr_req, busy, ovf;

    logic [7:0] mem [256];
    logic       ld_we = 1'b0;
    logic [7:0] ld_addr = 8'h00, ld_data = 8'h00;
    logic       exp_sel = 1'b0;
    int         n_chk = 0, n_pass = 0;

    always #5 clkm_48MHZ = ~clkm_48MHZ;

    always @(posedge clkm_48MHZ) begin
        if (ld_we) mem[ld_addr] <= ld_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    obj_scan_sched dut (
        .clkm_48MHZ(clkm_48MHZ), .reset(reset), .line_start(line_start), .vpos(vpos),
        .objex(objex), .obj_enable(obj_enable), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_code(desc_code),
        .desc_x(desc_x), .desc_row(desc_row), .desc_attr(desc_attr), .sel_buf(sel_buf),
        .clr_req(clr_req), .busy(busy), .ovf(ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clkm_48MHZ);
        #1;
    endtask

    task automatic put(input logic [7:0] a, input logic [7:0] v);
        ld_we = 1'b1; ld_addr = a; ld_data = v;
        tick;
        ld_we = 1'b0;
    endtask

    task automatic start_line(input logic [7:0] v, input logic bank, input logic en);
        vpos = v; objex = bank; obj_enable = en; line_start = 1'b1;
        tick;
        line_start = 1'b0;
        exp_sel = ~exp_sel;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while (busy && n < max) begin tick; n++; end
        chk(tag, busy, 0);
    endtask

    // Drain with ready high; objects i carry code 0x80+i, X i, row 3, attr 0.
    task automatic collect(output int n, output int bad);
        n = 0; bad = 0; desc_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (desc_valid) begin
                if (desc_code !== 8'(32'h80 + n) || desc_x !== 8'(n) ||
                    desc_row !== 4'h3 || desc_attr !== 8'h00) bad++;
                n++;
            end else if (!busy) break;
            tick;
        end
        desc_ready = 1'b0;
    endtask

    initial begin
        int cnt, saw, n, bad;
        for (int i = 0; i < 256; i++) put(8'(i), 8'h00);
        tick;
        reset = 1'b0;
        tick;
        chk("rst_sel", sel_buf, 0);
        chk("rst_clr", clr_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", desc_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ack", cpu_ack, 0);
        chk("rst_addr", ram_addr, 0);

        // Line start with scanning disabled
        start_line(8'h10, 1'b0, 1'b0);
        chk("off_sel", sel_buf, exp_sel);
        chk("off_clr", clr_req, 1);
        chk("off_busy", busy, 0);
        tick;
        chk("off_clr_end", clr_req, 0);
        chk("off_valid", desc_valid, 0);

        // Empty bank: 32 misses x 2 cycles
        desc_ready = 1'b1;
        start_line(8'h20, 1'b0, 1'b1);
        cnt = 0; saw = 0;
        while (busy && cnt < 200) begin
            if (desc_valid) saw++;
            cnt++;
            tick;
        end
        chk("miss_busy_cycles", cnt, 64);
        chk("miss_no_desc", saw, 0);
        desc_ready = 1'b0;

        // Single hit, object 3, Y=0xC8 with vpos 0x2A gives d=0xF3
        put(8'd12, 8'hC8); put(8'd13, 8'h40); put(8'd14, 8'h7A); put(8'd15, 8'h01);
        start_line(8'h2A, 1'b0, 1'b1);
        wait_idle("hit_idle", 200);
        chk("hit_valid", desc_valid, 1);
        chk("hit_code", desc_code, 8'h7A);
        chk("hit_x", desc_x, 8'h40);
        chk("hit_row", desc_row, 4'h3);
        chk("hit_attr", desc_attr, 8'h01);
        desc_ready = 1'b1; tick; desc_ready = 1'b0;
        chk("hit_popped", desc_valid, 0);

        put(8'd15, 8'h02);
        start_line(8'h2A, 1'b0, 1'b1);
        wait_idle("vflip_idle", 200);
        chk("vflip_row", desc_row, 4'hC);
        chk("vflip_attr", desc_attr, 8'h02);
        desc_ready = 1'b1; tick; desc_ready = 1'b0;

        // Z80 writes every other cycle during the same scan
        put(8'd15, 8'h01);
        start_line(8'h2A, 1'b0, 1'b1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h09; cpu_din = 8'h55;
            #1;
            if (!(ram_we && ram_addr == 8'h09 && ram_wdata == 8'h55)) bad++;
            tick;
            if (!cpu_ack || cpu_dout !== 8'h00) bad++;
            cpu_req = 1'b0;
            tick;
            if (cpu_ack) bad++;
        end
        chk("cpu_grant_ack", bad, 0);
        chk("cpu_scan_busy", busy, 1);
        wait_idle("cpu_idle", 200);
        chk("cpu_desc_code", desc_code, 8'h7A);
        chk("cpu_desc_x", desc_x, 8'h40);
        chk("cpu_desc_row", desc_row, 4'h3);
        chk("cpu_desc_attr", desc_attr, 8'h01);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h09;
        tick;
        chk("cpu_rd_ack", cpu_ack, 1);
        chk("cpu_rd_data", cpu_dout, 8'h55);
        cpu_req = 1'b0;
        desc_ready = 1'b1; tick; desc_ready = 1'b0;

        // Twenty in-range objects in bank 0
        for (int i = 0; i < 20; i++) begin
            put(8'(4 * i), 8'hC8); put(8'(4 * i + 1), 8'(i));
            put(8'(4 * i + 2), 8'(32'h80 + i)); put(8'(4 * i + 3), 8'h00);
        end
        start_line(8'h2A, 1'b1, 1'b1);
        wait_idle("bank1_idle", 200);
        chk("bank1_none", desc_valid, 0);

        start_line(8'h2A, 1'b0, 1'b1);
        repeat (60) tick;
        chk("stall_busy", busy, 1);
        chk("stall_valid", desc_valid, 1);
        chk("stall_head", desc_code, 8'h80);
        chk("stall_ovf", ovf, 0);
        collect(n, bad);
        chk("ovf_count", n, 16);
        chk("ovf_order", bad, 0);
        chk("ovf_flag", ovf, 1);
        chk("ovf_busy", busy, 0);

        // Abort with two descriptors queued
        start_line(8'h2A, 1'b0, 1'b1);
        repeat (16) tick;
        chk("abort_pre_valid", desc_valid, 1);
        start_line(8'h2A, 1'b0, 1'b1);
        chk("abort_flush", desc_valid, 0);
        chk("abort_sel", sel_buf, exp_sel);
        chk("abort_ovf", ovf, 0);
        chk("abort_busy", busy, 1);
        collect(n, bad);
        chk("abort_count", n, 16);
        chk("abort_order", bad, 0);

        // Reset mid-scan, with a Z80 request arriving in the same cycle
        start_line(8'h2A, 1'b0, 1'b1);
        repeat (10) tick;
        reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
        tick;
        chk("mrst_sel", sel_buf, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", desc_valid, 0);
        chk("mrst_code", desc_code, 0);
        chk("mrst_ovf", ovf, 0);
        chk("mrst_clr", clr_req, 0);
        chk("mrst_addr", ram_addr, 0);
        chk("mrst_we", ram_we, 0);
        cpu_req = 1'b0; reset = 1'b0; exp_sel = 1'b0;
        tick;
        chk("mrst_no_ack", cpu_ack, 0);
        chk("mrst_dout", cpu_dout, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
